// File: rtl/inst_legal_gate.sv
// Legality gate between fetch and decode: whitelist check on each instruction,
// one registered valid/ready stage for legal words, a held trap for illegal ones.
module inst_legal_gate #(
  parameter int XLEN     = 64,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ECALL = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic             trap_valid,
  input  logic             trap_ack,
  output logic [31:0]      trap_inst,
  output logic [XLEN-1:0]  trap_pc,
  output logic             halt,
  output logic [CNT_W-1:0] ill_cnt
);

  // Valid/ready: a word moves on every edge where valid and ready are both high;
  // the sender keeps valid and payload steady until then, and ready may depend
  // combinationally on the receiver's ready.

  localparam bit          RV64   = (XLEN == 64);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       shamt_ok;
  logic       legal;
  logic       accept;
  logic       acc_legal;
  logic       acc_illegal;

  assign opcode   = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  // On RV32 the shift amount is only 5 bits, so bit 25 must stay clear.
  assign shamt_ok = RV64 || !in_inst[25];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0110011: legal = (f7 == 7'h00)
                       || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                       || (EN_M && f7 == 7'h01);
      7'b0010011: begin
        case (f3)
          3'd1:    legal = (in_inst[31:26] == 6'h00) && shamt_ok;
          3'd5:    legal = (in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10) && shamt_ok;
          default: legal = 1'b1;
        endcase
      end
      7'b0011011: legal = RV64 && ((f3 == 3'd0)
                       || (f3 == 3'd1 && f7 == 7'h00)
                       || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
      7'b0111011: legal = RV64 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5))
                       || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                       || (EN_M && f7 == 7'h01 && f3 != 3'd1 && f3 != 3'd2 && f3 != 3'd3));
      7'b1100011: legal = (f3 != 3'd2) && (f3 != 3'd3);
      7'b1100111: legal = (f3 == 3'd0);
      7'b1101111,
      7'b0110111,
      7'b0010111: legal = 1'b1;
      7'b0000011: legal = (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7)
                       || (RV64 && (f3 == 3'd3 || f3 == 3'd6));
      7'b0100011: legal = (f3 <= 3'd2) || (RV64 && f3 == 3'd3);
      7'b1110011: legal = (in_inst == EBREAK) || (EN_ECALL && in_inst == ECALL);
      default:    legal = 1'b0;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign acc_legal   = accept && legal;
  assign acc_illegal = accept && !legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (acc_illegal) begin
          state_next = FAULT;
        end else if (acc_legal && in_inst == EBREAK) begin
          state_next = HALT;
        end
      end
      FAULT: begin
        if (trap_ack) begin
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    trap_valid = 1'b0;
    halt       = 1'b0;
    case (state)
      RUN:     in_ready   = !out_valid || out_ready;
      FAULT:   trap_valid = 1'b1;
      HALT:    halt       = 1'b1;
      default: in_ready   = 1'b0;
    endcase
  end

  // A new legal word overwrites the stage even while the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (acc_legal) begin
      out_valid <= 1'b1;
      out_inst  <= in_inst;
      out_pc    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_inst <= '0;
      trap_pc   <= '0;
      ill_cnt   <= '0;
    end else if (acc_illegal) begin
      trap_inst <= in_inst;
      trap_pc   <= in_pc;
      if (ill_cnt != {CNT_W{1'b1}}) begin
        ill_cnt <= ill_cnt + 1'b1;
      end
    end
  end

endmodule
